wots_multi_chain: RTL
=====================

WOTS_MULTI_CHAIN -- requirements
Module: wots_multi_chain

Interface
REQ-001 SHALL have parameter WOTS_W, default 16, Winternitz parameter; LOG_W = CLOG2(WOTS_W).
REQ-002 SHALL have parameter WOTS_LEN, default 67, number of chains per leaf/signature.
REQ-003 SHALL have parameter KEY_LEN, default 256, width of chain values.
REQ-004 SHALL have parameter NUM_CH, default 2, range 1..4, number of attached gen_chain engines.
REQ-005 Ports, one clock, reset synchronous active-high:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle job start
- mode  in  2  0=keygen, 1=sign, 2=pk_from_sig; 3 reserved
- pub_seed  in  KEY_LEN  key passed to engines
- hash_addr  in  256  base OTS address
- msg_digits  in  WOTS_LEN*LOG_W  digit i at [i*LOG_W +: LOG_W]
- in_valid / in_ready  in / out  1 / 1  chain input stream handshake
- in_data  in  KEY_LEN  chain input, element i in order
- out_valid / out_ready  out / in  1 / 1  result stream handshake
- out_data  out  KEY_LEN  chain result
- out_index  out  CLOG2(WOTS_LEN)  chain index of out_data
- busy  out  1  job active
- done  out  1  one-cycle completion pulse
- ch_start  out  NUM_CH  per-engine start pulse
- ch_input_data  out  KEY_LEN  shared
- ch_input_key  out  KEY_LEN  shared
- ch_start_step, ch_end_step  out  LOG_W each  shared
- ch_hash_addr  out  256  shared
- ch_done  in  NUM_CH  per-engine done pulse
- ch_data_out  in  NUM_CH*KEY_LEN  engine e at [e*KEY_LEN +: KEY_LEN]

Function
REQ-006 FSM states IDLE, RUN, FINISH; IDLE->RUN on start; RUN->FINISH when all WOTS_LEN results accepted on output; FINISH->IDLE next cycle with done=1.
REQ-007 start while busy=1, or with mode=3, SHALL be ignored.
REQ-008 On accepted start: latch mode, pub_seed, hash_addr, msg_digits; clear dispatch index d, collect index c, holding flags.
REQ-009 Chain i SHALL be dispatched to engine e = i mod NUM_CH, in increasing i, at most one dispatch per cycle.
REQ-010 Dispatch of i requires: RUN, d<WOTS_LEN, in_valid=1, engine e idle (not running, holding register empty); in_ready equals this condition.
REQ-011 On dispatch: ch_start[e]=1 for that cycle; ch_input_data=in_data; ch_input_key=pub_seed; ch_hash_addr=hash_addr with bits [95:64] (chain word) replaced by i, all other bits unchanged.
REQ-012 Steps: keygen start=0,end=WOTS_W-1; sign start=0,end=digit i; pk_from_sig start=digit i,end=WOTS_W-1; start=end SHALL still dispatch.
REQ-013 ch_done[e] SHALL capture ch_data_out slice e into holding register e and set its full flag same edge; ch_done on a non-running engine SHALL be ignored.
REQ-014 out_valid = holding register (c mod NUM_CH) full; out_data from it; out_index=c; on out_valid&out_ready clear flag, c++ — output strictly in index order.
REQ-015 Capture and collection on the same engine in the same cycle cannot occur (engine not re-dispatched until collected); dispatch to an engine in the cycle its flag clears SHALL wait one cycle.
REQ-016 out_ready low SHALL stall dispatch only through REQ-010; no result lost or duplicated.
REQ-017 busy=1 in RUN and FINISH; done high exactly one cycle, in FINISH.
REQ-018 Index counters SHALL be CLOG2(WOTS_LEN+1) wide; engine pointer wraps NUM_CH-1 -> 0.

Reset
REQ-019 reset SHALL force IDLE, clear d, c, running and full flags; busy, done, ch_start, in_ready, out_valid = 0; data outputs 0.
REQ-020 reset mid-job SHALL abort; ch_done arriving afterwards SHALL be ignored.

Structure
REQ-021 Mode encodings, chain-word bit range [95:64] and CLOG2 macro SHALL live in the shared XMSS parameter package.
REQ-022 One sub-module natural: chain_result_buf (NUM_CH holding registers, full flags, in-order read pointer).

Verification
REQ-023 NUM_CH=1, keygen, WOTS_LEN=67, in_data=i: 67 outputs indices 0..66, each equals reference chain(i,0..15), then done once.
REQ-024 NUM_CH=3, pk_from_sig with digits from existing sign vector: outputs match pk of gen_leaf vector with sec_seed d09f...f4b4, hash_addr 0.
REQ-025 NUM_CH=2, engines with random latencies 5..200 cycles: output order 0..66 preserved, ch_hash_addr[95:64]=i at every dispatch.
REQ-026 out_ready toggled 30% random plus held low 500 cycles: no loss/duplication; in_ready=0 while both engines hold results.
REQ-027 reset asserted at dispatch 20 then new start mode=1, all digits 0: all outputs equal in_data (start=end=0), stale ch_done ignored.
REQ-028 start during busy and mode=3 start: no effect, busy/done unchanged.

Source files
------------

// File: rtl/wots_multi_chain_pkg.sv
// Shared XMSS/WOTS definitions: job mode encodings, FSM states, the chain-word
// field of the 256-bit OTS address and a ceil-log2 helper for sizing.
package wots_multi_chain_pkg;

    typedef enum logic [1:0] {
        MODE_KEYGEN      = 2'd0,
        MODE_SIGN        = 2'd1,
        MODE_PK_FROM_SIG = 2'd2,
        MODE_RSVD        = 2'd3
    } wots_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } wmc_state_e;

    localparam int ADDR_W         = 256;
    localparam int CHAIN_WORD_LSB = 64;
    localparam int CHAIN_WORD_MSB = 95;

    // Ceil-log2, never below 1 so degenerate sizes still give a legal vector.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/wots_multi_chain_result_buf.sv
// One holding register per chain engine with a full flag, read back strictly in
// chain-index order through a wrapping engine pointer.
module wots_multi_chain_result_buf
    import wots_multi_chain_pkg::*;
#(
    parameter int  NUM_CH  = 2,
    parameter int  KEY_LEN = 256,
    localparam int PTR_W   = clog2(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [NUM_CH-1:0]         cap_en,
    input  logic [NUM_CH*KEY_LEN-1:0] cap_data,
    input  logic                      pop,
    output logic [NUM_CH-1:0]         full,
    output logic                      out_valid,
    output logic [KEY_LEN-1:0]        out_data
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_CH - 1);

    logic [KEY_LEN-1:0] hold_q [NUM_CH];
    logic [NUM_CH-1:0]  full_q, full_d;
    logic [PTR_W-1:0]   rd_q, rd_d;

    // An engine is never re-dispatched before its slot is popped, so a capture
    // and a pop never target the same slot in one cycle.
    always_comb begin
        full_d = full_q;
        rd_d   = rd_q;
        if (clear) begin
            full_d = '0;
            rd_d   = '0;
        end else begin
            full_d = full_q | cap_en;
            if (pop) begin
                full_d[rd_q] = 1'b0;
                rd_d         = (rd_q == LAST_PTR) ? '0 : rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= '0;
            rd_q   <= '0;
            for (int e = 0; e < NUM_CH; e++) begin
                hold_q[e] <= '0;
            end
        end else begin
            full_q <= full_d;
            rd_q   <= rd_d;
            for (int e = 0; e < NUM_CH; e++) begin
                if (cap_en[e]) begin
                    hold_q[e] <= cap_data[e*KEY_LEN +: KEY_LEN];
                end
            end
        end
    end

    assign full      = full_q;
    assign out_valid = full_q[rd_q];
    assign out_data  = hold_q[rd_q];

endmodule

// File: rtl/wots_multi_chain.sv
// Distributes the WOTS_LEN chains of one OTS job round-robin over NUM_CH
// gen_chain engines and streams the chain results back in index order.
module wots_multi_chain
    import wots_multi_chain_pkg::*;
#(
    parameter int  WOTS_W   = 16,
    parameter int  WOTS_LEN = 67,
    parameter int  KEY_LEN  = 256,
    parameter int  NUM_CH   = 2,
    localparam int LOG_W    = clog2(WOTS_W),
    localparam int IDX_W    = clog2(WOTS_LEN)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic [KEY_LEN-1:0]        pub_seed,
    input  logic [ADDR_W-1:0]         hash_addr,
    input  logic [WOTS_LEN*LOG_W-1:0] msg_digits,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [KEY_LEN-1:0]        in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [KEY_LEN-1:0]        out_data,
    output logic [IDX_W-1:0]          out_index,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_CH-1:0]         ch_start,
    output logic [KEY_LEN-1:0]        ch_input_data,
    output logic [KEY_LEN-1:0]        ch_input_key,
    output logic [LOG_W-1:0]          ch_start_step,
    output logic [LOG_W-1:0]          ch_end_step,
    output logic [ADDR_W-1:0]         ch_hash_addr,
    input  logic [NUM_CH-1:0]         ch_done,
    input  logic [NUM_CH*KEY_LEN-1:0] ch_data_out,
    output wmc_state_e                dbg_state
);

    localparam int CNT_W = clog2(WOTS_LEN + 1);
    localparam int PTR_W = clog2(NUM_CH);

    localparam logic [CNT_W-1:0]  LEN_CNT  = CNT_W'(WOTS_LEN);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WOTS_LEN - 1);
    localparam logic [PTR_W-1:0]  LAST_ENG = PTR_W'(NUM_CH - 1);
    localparam logic [LOG_W-1:0]  MAX_STEP = LOG_W'(WOTS_W - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK =
        {{(ADDR_W-CHAIN_WORD_MSB-1){1'b0}}, {(CHAIN_WORD_MSB-CHAIN_WORD_LSB+1){1'b1}},
         {CHAIN_WORD_LSB{1'b0}}};

    wmc_state_e                state_q;
    wots_mode_e                mode_q;
    logic [KEY_LEN-1:0]        seed_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [WOTS_LEN*LOG_W-1:0] digits_q;
    logic [CNT_W-1:0]          d_q;
    logic [CNT_W-1:0]          c_q;
    logic [PTR_W-1:0]          eng_q;
    logic [NUM_CH-1:0]         running_q;

    logic                      start_ok;
    logic                      dispatch;
    logic                      pop;
    logic                      buf_valid;
    logic [NUM_CH-1:0]         full;
    logic [NUM_CH-1:0]         cap_en;
    logic [NUM_CH-1:0]         disp_oh;
    logic [LOG_W-1:0]          digit;
    logic [LOG_W-1:0]          step_lo;
    logic [LOG_W-1:0]          step_hi;
    logic [ADDR_W-1:0]         addr_chain;

    assign start_ok = (state_q == ST_IDLE) && start && (mode != MODE_RSVD);

    // Both streams transfer on the rising edge where valid and ready are high;
    // in_ready already folds in in_valid, and out_valid never depends on out_ready.
    assign dispatch = (state_q == ST_RUN) && (d_q < LEN_CNT) && in_valid
                      && !running_q[eng_q] && !full[eng_q];
    assign disp_oh  = dispatch ? (NUM_CH'(1) << eng_q) : '0;
    assign cap_en   = ch_done & running_q;
    assign pop      = buf_valid & out_ready;

    always_comb begin
        digit   = digits_q[int'(d_q)*LOG_W +: LOG_W];
        step_lo = '0;
        step_hi = MAX_STEP;
        case (mode_q)
            MODE_SIGN:        step_hi = digit;
            MODE_PK_FROM_SIG: step_lo = digit;
            default:          ;
        endcase
        addr_chain = addr_q | ({{(ADDR_W-CNT_W){1'b0}}, d_q} << CHAIN_WORD_LSB);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_KEYGEN;
            seed_q    <= '0;
            addr_q    <= '0;
            digits_q  <= '0;
            d_q       <= '0;
            c_q       <= '0;
            eng_q     <= '0;
            running_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        mode_q    <= wots_mode_e'(mode);
                        seed_q    <= pub_seed;
                        addr_q    <= hash_addr & ~WORD_MASK;
                        digits_q  <= msg_digits;
                        d_q       <= '0;
                        c_q       <= '0;
                        eng_q     <= '0;
                        running_q <= '0;
                        state_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (dispatch) begin
                        d_q   <= d_q + 1'b1;
                        eng_q <= (eng_q == LAST_ENG) ? '0 : eng_q + 1'b1;
                    end
                    if (pop) begin
                        c_q <= c_q + 1'b1;
                        if (c_q == LAST_IDX) begin
                            state_q <= ST_FINISH;
                        end
                    end
                    running_q <= (running_q & ~cap_en) | disp_oh;
                end
                ST_FINISH: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    wots_multi_chain_result_buf #(
        .NUM_CH  (NUM_CH),
        .KEY_LEN (KEY_LEN)
    ) u_result_buf (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .cap_en    (cap_en),
        .cap_data  (ch_data_out),
        .pop       (pop),
        .full      (full),
        .out_valid (buf_valid),
        .out_data  (out_data)
    );

    assign in_ready      = dispatch;
    assign ch_start      = disp_oh;
    assign ch_input_data = dispatch ? in_data : '0;
    assign ch_input_key  = dispatch ? seed_q : '0;
    assign ch_start_step = dispatch ? step_lo : '0;
    assign ch_end_step   = dispatch ? step_hi : '0;
    assign ch_hash_addr  = dispatch ? addr_chain : '0;

    assign out_valid = buf_valid;
    assign out_index = c_q[IDX_W-1:0];
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FINISH);
    assign dbg_state = state_q;

endmodule
